div_seq_ctrl: RTL
=================

// Module: div_seq_ctrl
// PURPOSE
//  Sequencer for the one-hot event divider (inputs c_up/clr, output dclk; one dclk period per 6 c_up).
//  Accepts a job over a valid/ready handshake. Clears the divider, then paces c_up pulses with a programmable gap.
//  Counts dclk periods and reports done after the requested count, or aborted on request.
//  Sits between the control logic and the divider instance; it is the only driver of the divider's c_up and clr.
// PARAMETERS
//  GW  4  width of cfg_gap: idle cycles between consecutive c_up pulses
//  PW  8  width of cfg_periods and per_cnt: dclk periods per job
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_b        in   1   reset, synchronous, active-low
//  cfg_valid    in   1   job request valid
//  cfg_ready    out  1   controller can accept a job (IDLE only)
//  cfg_gap      in   GW  gap between c_up pulses, sampled on accept
//  cfg_periods  in   PW  dclk periods to run, sampled on accept
//  abort        in   1   stop the current job
//  dclk         in   1   divider output (high in divider state S0)
//  c_up         out  1   count pulse to divider
//  clr          out  1   clear to divider (forces divider to S0)
//  busy         out  1   state != IDLE
//  done         out  1   1-cycle pulse: job completed
//  aborted      out  1   1-cycle pulse: job aborted
//  per_cnt      out  PW  dclk periods completed in current/last job
// BEHAVIOUR
//  Clock and reset
//   - Single clock; reset is synchronous and active-low.
//   - rst_b=0 at a clk edge: state=IDLE, gap_cnt=0, per_cnt=0, dclk_q=1, latched cfg=0.
//   - All outputs are decoded from registers. Values after reset: c_up=0, clr=0, done=0, aborted=0, busy=0, cfg_ready=1.
//   - Reset mid-job drops the job silently: no done, no aborted pulse.
//  States: IDLE, CLEAR, RUN, DONE, ABORT
//   - IDLE:  cfg_ready=1.
//            cfg_valid=1 at an edge: latch cfg_gap/cfg_periods, per_cnt<=0, go to CLEAR.
//            abort is ignored in IDLE.
//   - CLEAR: clr=1 for exactly 1 cycle. gap_cnt<=0, dclk_q<=1.
//            abort=1 -> ABORT; else cfg_periods==0 -> DONE; else -> RUN.
//   - RUN:   c_up = (gap_cnt==0).
//            After a pulse gap_cnt<=cfg_gap; otherwise it decrements.
//            Net effect: one c_up every cfg_gap+1 cycles, the first one in the first RUN cycle.
//            rise = dclk & ~dclk_q; dclk_q<=dclk every RUN cycle.
//            On rise: per_cnt<=per_cnt+1. If per_cnt+1==cfg_periods: go to DONE; c_up forced 0 that cycle.
//   - DONE:  done=1 for 1 cycle, c_up=0, then IDLE.
//   - ABORT: clr=1 and aborted=1 for 1 cycle, then IDLE.
//  Priority and handshake
//   - abort in CLEAR or RUN beats period completion in the same cycle -> ABORT, no done.
//   - cfg_valid while busy is ignored (not queued). The requester holds valid until it sees ready.
//   - per_cnt holds its final value in IDLE until the next accept.
//   - per_cnt saturates at 2^PW-1.
//  Latency
//   - Accept at edge k -> clr high in cycle k+1 -> first c_up in cycle k+2.
//   - done is high in the cycle after the edge where the final rise is detected.
// TESTING (divider model: 6-state one-hot, dclk=S0)
//  1 rst_b=0 for 2 edges -> c_up=0 clr=0 busy=0 done=0 aborted=0 cfg_ready=1 per_cnt=0.
//  2 gap=0 periods=2 -> clr 1 cycle; c_up every cycle, 12 pulses total; done 1 cycle; per_cnt=2; IDLE.
//  3 gap=2 periods=1, cfg_valid held during job -> c_up spacing 3 cycles, 6 pulses, one job only.
//  4 gap=0 periods=5, abort after 8 c_up -> next cycle clr=1 aborted=1, per_cnt=1, no done.
//  5 periods=0 -> clr 1 cycle then done 1 cycle, zero c_up pulses, per_cnt=0.
//  6 abort on the same cycle as the final dclk rise -> aborted=1, done stays 0.

Source files
------------

// File: rtl/div_seq_ctrl_if.sv
// Job interface of the divider sequencer.
//   cfg_valid / cfg_ready : job request handshake (accepted when both are high at a clk edge)
//   cfg_gap               : idle cycles between consecutive c_up pulses
//   cfg_periods           : dclk periods to run for the job
//   abort                 : stop the current job
//   busy                  : sequencer is not idle
//   done / aborted        : one-cycle completion pulses
//   per_cnt               : dclk periods completed in the current or last job
// master: the requesting control logic. slave: the sequencer.
interface div_seq_ctrl_if #(
    parameter int unsigned GW = 4,
    parameter int unsigned PW = 8
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [GW-1:0] cfg_gap;
    logic [PW-1:0] cfg_periods;
    logic          abort;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [PW-1:0] per_cnt;

    modport master (
        output cfg_valid,
        output cfg_gap,
        output cfg_periods,
        output abort,
        input  cfg_ready,
        input  busy,
        input  done,
        input  aborted,
        input  per_cnt
    );

    modport slave (
        input  cfg_valid,
        input  cfg_gap,
        input  cfg_periods,
        input  abort,
        output cfg_ready,
        output busy,
        output done,
        output aborted,
        output per_cnt
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer for a six-state one-hot event divider (one dclk period per 6 c_up pulses).
// A job is accepted over a valid/ready handshake; the sequencer clears the divider, paces
// c_up pulses with a programmable gap, counts dclk periods and reports done after the
// requested count, or aborted on request. It is the sole driver of the divider's c_up/clr.
// Ports:
//   clk    in   system clock, rising edge
//   rst_b  in   synchronous active-low reset
//   job    slave modport of div_seq_ctrl_if (config handshake, abort, status)
//   dclk   in   divider output, high while the divider sits in its first state
//   c_up   out  count pulse to the divider
//   clr    out  clear to the divider (forces it to its first state)
module div_seq_ctrl #(
    parameter int unsigned GW = 4,
    parameter int unsigned PW = 8
) (
    input  logic           clk,
    input  logic           rst_b,
    div_seq_ctrl_if.slave  job,
    input  logic           dclk,
    output logic           c_up,
    output logic           clr
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDone,
        StAbort
    } state_e;

    localparam logic [PW:0] PerOne = {{PW{1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [GW-1:0] cfg_gap_q, cfg_gap_d;
    logic [PW-1:0] cfg_per_q, cfg_per_d;
    logic [PW-1:0] per_cnt_q, per_cnt_d;
    logic          dclk_q, dclk_d;

    logic          rise;
    logic          last_period;
    logic [PW:0]   per_next_w;
    logic [PW-1:0] per_inc;

    logic          cfg_ready;
    logic          busy;
    logic          done;
    logic          aborted;

    // Period arithmetic is done one bit wider so the completion compare cannot wrap,
    // and the carry out doubles as the saturation flag.
    always_comb begin
        rise        = dclk & ~dclk_q;
        per_next_w  = {1'b0, per_cnt_q} + PerOne;
        last_period = (per_next_w == {1'b0, cfg_per_q});
        per_inc     = per_next_w[PW] ? per_cnt_q : per_next_w[PW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        cfg_gap_d = cfg_gap_q;
        cfg_per_d = cfg_per_q;
        per_cnt_d = per_cnt_q;
        dclk_d    = dclk_q;
        c_up      = 1'b0;
        clr       = 1'b0;
        done      = 1'b0;
        aborted   = 1'b0;
        cfg_ready = 1'b0;
        busy      = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                cfg_ready = 1'b1;
                // abort is deliberately not looked at here.
                if (job.cfg_valid) begin
                    cfg_gap_d = job.cfg_gap;
                    cfg_per_d = job.cfg_periods;
                    per_cnt_d = '0;
                    state_d   = StClear;
                end
            end

            StClear: begin
                clr       = 1'b1;
                gap_cnt_d = '0;
                // Divider is forced to its dclk-high state, so start the edge detector there.
                dclk_d    = 1'b1;
                if (job.abort) begin
                    state_d = StAbort;
                end else if (cfg_per_q == '0) begin
                    state_d = StDone;
                end else begin
                    state_d = StRun;
                end
            end

            StRun: begin
                dclk_d = dclk;
                // Suppress the pulse on the final rise so the divider is left at rest.
                c_up   = (gap_cnt_q == '0) && !(rise && last_period);
                if (gap_cnt_q == '0) begin
                    gap_cnt_d = cfg_gap_q;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
                if (rise) begin
                    per_cnt_d = per_inc;
                end
                // Abort wins over completion in the same cycle.
                if (job.abort) begin
                    state_d = StAbort;
                end else if (rise && last_period) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            StAbort: begin
                clr     = 1'b1;
                aborted = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            cfg_gap_q <= '0;
            cfg_per_q <= '0;
            per_cnt_q <= '0;
            dclk_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            cfg_gap_q <= cfg_gap_d;
            cfg_per_q <= cfg_per_d;
            per_cnt_q <= per_cnt_d;
            dclk_q    <= dclk_d;
        end
    end

    assign job.cfg_ready = cfg_ready;
    assign job.busy      = busy;
    assign job.done      = done;
    assign job.aborted   = aborted;
    assign job.per_cnt   = per_cnt_q;

endmodule
